// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with load/store sizing, misalign detection and MEM/WB registers
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_mem,
  input  logic [XLEN-1:0] pc_mem,
  input  logic [XLEN-1:0] alu_mem,
  input  logic [XLEN-1:0] rs2_mem,
  input  logic [XLEN-1:0] instr_mem,
  input  logic [4:0]      rd_addr_mem,
  output logic            stall_mem,
  output logic [XLEN-1:0] forward_mem,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] pc_wb,
  output logic [XLEN-1:0] alu_wb,
  output logic [XLEN-1:0] mem_wb,
  output logic [XLEN-1:0] instr_wb,
  output logic [4:0]      rd_addr_wb,
  output logic            valid_wb,
  output logic            misalign_wb
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, next_state;
  logic [2:0] f3;
  logic [1:0] a;
  logic is_ld, is_st, mis, mem_op;
  logic [XLEN-1:0] sh, ld_data;
  logic [3:0] st_be;
  assign f3 = instr_mem[14:12];
  assign a = alu_mem[1:0];
  assign is_ld = instr_mem[6:0] == 7'b0000011 && f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111;
  assign is_st = instr_mem[6:0] == 7'b0100011 && !f3[2] && f3 != 3'b011;
  assign mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
  assign mem_op = valid_mem && (is_ld || is_st) && !mis;
  assign dmem_req = !rst && mem_op;
  assign stall_mem = dmem_req && !dmem_ack;
  assign forward_mem = alu_mem;
  assign dmem_addr = {alu_mem[XLEN-1:2], 2'b00};
  assign dmem_we = dmem_req && is_st;
  assign st_be = f3[1] ? 4'b1111 : f3[0] ? 4'b0011 << {a[1], 1'b0} : 4'b0001 << a;
  assign dmem_be = is_ld ? 4'b1111 : st_be;
  assign dmem_wdata = f3[1] ? rs2_mem : f3[0] ? {2{rs2_mem[15:0]}} : {4{rs2_mem[7:0]}};
  // one lane shifter serves both bytes and (aligned) halves
  assign sh = dmem_rdata >> {a, 3'b000};
  assign ld_data = f3[1] ? dmem_rdata :
                   f3[0] ? {{16{~f3[2] & sh[15]}}, sh[15:0]} : {{24{~f3[2] & sh[7]}}, sh[7:0]};
  always_comb begin
    next_state = stall_mem ? WAIT : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc_wb       <= '0;
      alu_wb      <= '0;
      mem_wb      <= '0;
      instr_wb    <= '0;
      rd_addr_wb  <= '0;
      valid_wb    <= 1'b0;
      misalign_wb <= 1'b0;
    end else begin
      state <= next_state;
      if (stall_mem) begin
        valid_wb <= 1'b0;
      end else begin
        pc_wb       <= pc_mem;
        alu_wb      <= alu_mem;
        instr_wb    <= instr_mem;
        rd_addr_wb  <= rd_addr_mem;
        valid_wb    <= valid_mem;
        misalign_wb <= valid_mem && (is_ld || is_st) && mis;
        mem_wb      <= (mem_op && is_ld) ? ld_data : '0;
      end
    end
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 valid_mem  in  1  EXE/MEM slot holds a live instruction.
REQ-005 pc_mem / alu_mem / rs2_mem / instr_mem  in  XLEN each  EXE/MEM registers; alu_mem is the effective address for loads and stores.
REQ-006 rd_addr_mem  in  5  destination register.
REQ-007 stall_mem  out  1  holds EXE/MEM and all earlier stages.
REQ-008 forward_mem  out  XLEN  equals alu_mem, combinational, for EXE forwarding.
REQ-009 dmem_req, dmem_we  out  1 each  request strobe and write enable.
REQ-010 dmem_addr  out  XLEN  word-aligned address {alu_mem[31:2],2'b00}.
REQ-011 dmem_wdata  out  XLEN; dmem_be  out  4  byte-lane write data and enables.
REQ-012 dmem_ack  in  1; dmem_rdata  in  XLEN  completion and read word, valid with ack.
REQ-013 pc_wb, alu_wb, mem_wb, instr_wb  out  XLEN each; rd_addr_wb  out  5; valid_wb, misalign_wb  out  1 each  MEM/WB registers.

Function
REQ-014 Memory op decoding uses instr_mem[6:0]: 0000011 is load, 0100011 is store, all others are non-memory; width comes from funct3 instr_mem[14:12].
REQ-015 Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0; no dmem_req is issued, and the result retires next cycle with misalign_wb=1 and mem_wb=0.
REQ-016 FSM has two states, IDLE and WAIT; reset state is IDLE.
REQ-017 IDLE, aligned memory op with valid_mem=1: drive dmem_req=1 combinationally in the same cycle. If dmem_ack=1, retire at the next edge; otherwise go to WAIT.
REQ-018 WAIT: hold dmem_req=1 and keep dmem_addr/we/wdata/be stable. On dmem_ack=1, retire at the edge and return to IDLE.
REQ-019 stall_mem=1 exactly when an aligned memory op is valid and dmem_ack=0 in the current cycle (IDLE or WAIT); upstream inputs are guaranteed stable while stall_mem=1.
REQ-020 While stall_mem=1, the MEM/WB registers take a bubble: valid_wb=0 and the other WB registers hold their values.
REQ-021 Non-memory op or valid_mem=0: no request and no stall; WB registers load the inputs after 1 cycle, with valid_wb=valid_mem and mem_wb=0.
REQ-022 Store SB: wdata = rs2[7:0] replicated x4; be = 0001<<addr[1:0].
REQ-023 Store SH: wdata = rs2[15:0] replicated x2; be = 0011<<{addr[1],1'b0}.
REQ-024 Store SW: wdata = rs2; be = 1111.
REQ-025 Stores set dmem_we=1; mem_wb=0 on retire.
REQ-026 Loads set dmem_we=0 and be=1111. The selected byte/half (by addr[1:0]) is sign-extended for LB/LH and zero-extended for LBU/LHU; LW is passed through. The result is registered into mem_wb on the ack edge.
REQ-027 Unsupported funct3 on a load/store is treated as a non-memory op (no request).
REQ-028 dmem_ack arriving while dmem_req=0 is ignored.
REQ-029 Each retire passes pc, alu, instr and rd_addr unmodified to the WB registers.

Reset
REQ-030 rst=1 at a clock edge forces the following: state=IDLE; all WB registers = 0, including valid_wb and misalign_wb.
REQ-031 While rst=1, dmem_req=0 and stall_mem=0 regardless of inputs.
REQ-032 Reset during WAIT abandons the request; an ack arriving after reset is ignored.

Verification
REQ-033 ADD (valid, alu=0x10, rd=5) -> next cycle valid_wb=1, alu_wb=0x10, rd_addr_wb=5, mem_wb=0, no dmem_req, stall_mem=0.
REQ-034 LB, addr=0x103, rdata=0x80FF_FF_FF with ack in the same cycle -> mem_wb=0xFFFF_FF80 next cycle, dmem_addr=0x100, zero stall. LBU at the same address -> mem_wb=0x0000_0080.
REQ-035 SH, addr=0x22, rs2=0x1234ABCD, ack after 3 cycles -> dmem_addr=0x20, wdata=0xABCDABCD, be=1100, we=1. stall_mem=1 for 3 cycles, valid_wb=0 during those cycles, then valid_wb=1 for one cycle.
REQ-036 LW, addr=0x102 -> no dmem_req, stall_mem=0, next cycle valid_wb=1, misalign_wb=1, mem_wb=0.
REQ-037 LW issued with no ack for 2 cycles, then rst=1 -> dmem_req=0 and stall_mem=0 during reset, valid_wb=0, state IDLE. A stray ack after reset produces no retire.
REQ-038 Back-to-back SW then LW at the same address, both with zero-wait ack -> the SW retires with be=1111, then the LW returns the stored word in mem_wb, with no stall cycles.
